texture_upload_engine: RTL and testbench

TEXTURE_UPLOAD_ENGINE -- requirements
Module: texture_upload_engine

---
 rtl/texture_upload_engine_if.sv | 32 +++
 rtl/texture_upload_engine.sv | 133 +++++++++++++
 tb/tb_texture_upload_engine.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/texture_upload_engine_if.sv
// Source-stream and texture-memory write bus for the texture upload engine.
// The engine connects through the slave modport. The driver or testbench connects through the master modport.
interface texture_upload_engine_if;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 27;
  localparam int unsigned TEX_W   = 7;
  localparam int unsigned COUNT_W = 8;

  logic                 i_start;
  logic [TEX_W-1:0]     i_tex_base;
  logic [COUNT_W-1:0]   i_tex_count;
  logic                 i_abort;
  logic                 i_s_valid;
  logic [DATA_W-1:0]    i_s_data;
  logic                 o_s_ready;
  logic [DATA_W-1:0]    o_wdata;
  logic                 o_wea;
  logic [ADDR_W-1:0]    o_waddr;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;

  modport slave (
    input  i_start, i_tex_base, i_tex_count, i_abort, i_s_valid, i_s_data,
    output o_s_ready, o_wdata, o_wea, o_waddr, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_tex_base, i_tex_count, i_abort, i_s_valid, i_s_data,
    input  o_s_ready, o_wdata, o_wea, o_waddr, o_busy, o_done, o_err
  );
endinterface

// File: rtl/texture_upload_engine.sv
// Streams source words into consecutive 64-word texture slots of the texture memory.
// Each accepted beat becomes one registered write at MEM_BASE + tex*256 + word*4.
module texture_upload_engine #(
  parameter logic [26:0] MEM_BASE = 27'h0002000
) (
  input  logic                    clk,
  input  logic                    reset,
  texture_upload_engine_if.slave  bus
);
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 27;
  localparam int unsigned TEX_W   = 7;
  localparam int unsigned WORD_W  = 6;
  localparam int unsigned SPAN_W  = 9;
  localparam int unsigned TEX_LIM = 128;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [TEX_W-1:0]    tex_q, tex_d;
  logic [TEX_W-1:0]    last_tex_q, last_tex_d;
  logic                ready_q, ready_d;
  logic                wea_q, wea_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [SPAN_W-1:0]   span_c;
  logic                start_ok_c;
  logic                start_bad_c;
  logic                accept_c;
  logic                last_word_c;

  // Start legality: a non-empty range that ends at or below texture 128.
  always_comb begin
    span_c      = SPAN_W'(bus.i_tex_base) + SPAN_W'(bus.i_tex_count);
    start_ok_c  = bus.i_start && (bus.i_tex_count != '0) && (span_c <= SPAN_W'(TEX_LIM));
    start_bad_c = bus.i_start && !start_ok_c;
    accept_c    = bus.i_s_valid && ready_q;
    last_word_c = (word_q == WORD_W'(63)) && (tex_q == last_tex_q);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Abort wins over last-word completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok_c) state_d = S_STREAM;
      S_STREAM: begin
        if (bus.i_abort)                    state_d = S_IDLE;
        else if (accept_c && last_word_c)   state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    word_d     = word_q;
    tex_d      = tex_q;
    last_tex_d = last_tex_q;
    wea_d      = 1'b0;
    wdata_d    = wdata_q;
    waddr_d    = waddr_q;
    err_d      = 1'b0;
    ready_d    = (state_d == S_STREAM);
    busy_d     = (state_d == S_STREAM);
    done_d     = (state_d == S_DONE);

    if (state_q == S_IDLE) begin
      err_d = start_bad_c;
      if (start_ok_c) begin
        word_d     = '0;
        tex_d      = bus.i_tex_base;
        last_tex_d = TEX_W'(span_c - SPAN_W'(1));
      end
    end

    // An accepted beat is written even in the abort cycle.
    if (accept_c) begin
      wea_d   = 1'b1;
      wdata_d = bus.i_s_data;
      waddr_d = MEM_BASE + ADDR_W'({tex_q, word_q, 2'b00});
      word_d  = word_q + WORD_W'(1);
      if (word_q == WORD_W'(63)) tex_d = tex_q + TEX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q     <= '0;
      tex_q      <= '0;
      last_tex_q <= '0;
      ready_q    <= 1'b0;
      wea_q      <= 1'b0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      word_q     <= word_d;
      tex_q      <= tex_d;
      last_tex_q <= last_tex_d;
      ready_q    <= ready_d;
      wea_q      <= wea_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_s_ready = ready_q;
  assign bus.o_wea     = wea_q;
  assign bus.o_wdata   = wdata_q;
  assign bus.o_waddr   = waddr_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_err     = err_q;
endmodule

// File: tb/tb_texture_upload_engine.sv
// Bench for texture_upload_engine: start-vector table, scoreboarded write stream, abort/reset/restart sequences.
module tb_texture_upload_engine;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  texture_upload_engine_if bus();

  texture_upload_engine #(.MEM_BASE(27'h0002000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [26:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  typedef struct {
    int base;
    int count;
    bit err;
  } vec_t;

  wr_t         sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_cnt  = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [26:0] last_addr = '0;
  logic [31:0] data_ctr = '0;
  int          m_tex, m_word, m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every o_wea must match the oldest expected write; o_done only rides on the final write.
  always @(negedge clk) begin
    wr_t e;
    if (bus.o_wea === 1'b1) begin
      wr_cnt++;
      last_addr = bus.o_waddr;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", bus.o_waddr, bus.o_wdata);
      end else begin
        e = sb_q.pop_front();
        check("waddr", 32'(bus.o_waddr), 32'(e.addr));
        check("wdata", bus.o_wdata, e.data);
        check("done_with_last_write", 32'(bus.o_done), 32'(e.last));
      end
    end else if (bus.o_done === 1'b1) begin
      check("done_needs_wea", 32'(bus.o_wea), 32'd1);
    end
    if (bus.o_done === 1'b1) done_cnt++;
    if (bus.o_err === 1'b1) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, 32'(bus.o_s_ready), 32'd0);
    check({tag, "_wea"},     32'(bus.o_wea),     32'd0);
    check({tag, "_busy"},    32'(bus.o_busy),    32'd0);
    check({tag, "_done"},    32'(bus.o_done),    32'd0);
    check({tag, "_err"},     32'(bus.o_err),     32'd0);
    check({tag, "_wdata"},   bus.o_wdata,        32'd0);
    check({tag, "_waddr"},   32'(bus.o_waddr),   32'd0);
  endtask

  task automatic start_xfer(input int base, input int count);
    bus.i_start     = 1'b1;
    bus.i_tex_base  = 7'(base);
    bus.i_tex_count = 8'(count);
    tick();
    bus.i_start = 1'b0;
    m_tex  = base;
    m_word = 0;
    m_last = base + count - 1;
  endtask

  // Drives beats until n are accepted; expected writes are queued from the bench's own address model.
  task automatic stream(input int n, input bit gaps, input int abort_at, input int start_at, output int cycles);
    int  acc = 0;
    bit  abort_now;
    wr_t it;
    cycles = 0;
    while (acc < n && cycles < 4 * n + 100) begin
      bus.i_s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.i_s_data  = data_ctr;
      abort_now     = (abort_at > 0) && (acc == abort_at - 1);
      bus.i_abort   = abort_now;
      bus.i_start   = (start_at > 0) && (acc == start_at);
      if (bus.i_start) begin
        bus.i_tex_base  = 7'd0;
        bus.i_tex_count = 8'd5;
      end
      @(negedge clk);
      if (bus.i_s_valid && bus.o_s_ready) begin
        it.addr = 27'(32'h2000 + m_tex * 256 + m_word * 4);
        it.data = data_ctr;
        it.last = (m_word == 63) && (m_tex == m_last) && !abort_now;
        sb_q.push_back(it);
        m_word++;
        if (m_word == 64) begin
          m_word = 0;
          m_tex++;
        end
        acc++;
        data_ctr++;
      end
      tick();
      cycles++;
    end
    bus.i_s_valid = 1'b0;
    bus.i_abort   = 1'b0;
    bus.i_start   = 1'b0;
    check("beats_accepted", 32'(acc), 32'(n));
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int cyc, w0, d0, e0, n_err_vec;
    vecs[0] = '{0,   0,   1'b1};
    vecs[1] = '{127, 2,   1'b1};
    vecs[2] = '{1,   128, 1'b1};
    vecs[3] = '{0,   129, 1'b1};
    vecs[4] = '{64,  65,  1'b1};
    vecs[5] = '{0,   128, 1'b0};
    vecs[6] = '{127, 1,   1'b0};
    vecs[7] = '{64,  64,  1'b0};

    reset = 1'b1;
    bus.i_start = 1'b0; bus.i_tex_base = '0; bus.i_tex_count = '0;
    bus.i_abort = 1'b0; bus.i_s_valid = 1'b0; bus.i_s_data = '0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Start legality table; accepted starts are aborted straight away with no beats.
    e0 = err_cnt;
    w0 = wr_cnt;
    n_err_vec = 0;
    for (int i = 0; i < 8; i++) begin
      start_xfer(vecs[i].base, vecs[i].count);
      check($sformatf("vec%0d_err", i),   32'(bus.o_err),     32'(vecs[i].err));
      check($sformatf("vec%0d_busy", i),  32'(bus.o_busy),    32'(!vecs[i].err));
      check($sformatf("vec%0d_ready", i), 32'(bus.o_s_ready), 32'(!vecs[i].err));
      if (vecs[i].err) n_err_vec++;
      tick();
      check($sformatf("vec%0d_err_one_cycle", i), 32'(bus.o_err), 32'd0);
      if (!vecs[i].err) begin
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        check($sformatf("vec%0d_abort_idle", i), 32'(bus.o_busy), 32'd0);
      end
      tick();
    end
    check("table_err_pulses", 32'(err_cnt - e0), 32'(n_err_vec));
    check("table_no_writes", 32'(wr_cnt - w0), 32'd0);

    // Single texture at base 0, 64 back-to-back beats with data = k.
    w0 = wr_cnt; d0 = done_cnt;
    data_ctr = '0;
    start_xfer(0, 1);
    stream(64, 1'b0, 0, 0, cyc);
    check("b2b_cycles", 32'(cyc), 32'd64);
    check("last_beat_done", 32'(bus.o_done), 32'd1);
    check("last_beat_wea", 32'(bus.o_wea), 32'd1);
    check("last_beat_addr", 32'(bus.o_waddr), 32'h20FC);
    check("ready_low_after_last", 32'(bus.o_s_ready), 32'd0);
    tick();
    check("done_one_cycle", 32'(bus.o_done), 32'd0);
    check("idle_after_done", 32'(bus.o_busy), 32'd0);
    check("hold_waddr", 32'(bus.o_waddr), 32'h20FC);
    check("hold_wdata", bus.o_wdata, 32'd63);
    drain();
    check("t0_writes", 32'(wr_cnt - w0), 32'd64);
    check("t0_done", 32'(done_cnt - d0), 32'd1);

    // Top texture slot.
    start_xfer(127, 1);
    stream(64, 1'b0, 0, 0, cyc);
    drain();
    check("t127_last_addr", 32'(last_addr), 32'h9FFC);

    // base 5, count 2, with random valid gaps.
    w0 = wr_cnt; d0 = done_cnt;
    start_xfer(5, 2);
    stream(128, 1'b1, 0, 0, cyc);
    drain();
    tick();
    check("gaps_writes", 32'(wr_cnt - w0), 32'd128);
    check("gaps_last_addr", 32'(last_addr), 32'h26FC);
    check("gaps_done", 32'(done_cnt - d0), 32'd1);

    // Abort on the 10th beat, then restart from word 0.
    w0 = wr_cnt; d0 = done_cnt;
    start_xfer(20, 2);
    stream(10, 1'b0, 10, 0, cyc);
    check("abort_idle", 32'(bus.o_busy), 32'd0);
    check("abort_ready_low", 32'(bus.o_s_ready), 32'd0);
    check("abort_beat_written", 32'(bus.o_wea), 32'd1);
    drain();
    repeat (3) tick();
    check("abort_writes", 32'(wr_cnt - w0), 32'd10);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    w0 = wr_cnt; d0 = done_cnt;
    start_xfer(3, 1);
    stream(64, 1'b0, 0, 0, cyc);
    drain();
    check("restart_writes", 32'(wr_cnt - w0), 32'd64);
    check("restart_done", 32'(done_cnt - d0), 32'd1);
    check("restart_last_addr", 32'(last_addr), 32'h23FC);

    // Reset after 20 beats while the source keeps offering data.
    w0 = wr_cnt; d0 = done_cnt;
    start_xfer(0, 4);
    stream(20, 1'b0, 0, 0, cyc);
    reset = 1'b1;
    bus.i_s_valid = 1'b1;
    bus.i_s_data  = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0;
    bus.i_s_valid = 1'b0;
    check_all_zero("midreset");
    repeat (5) tick();
    check("midreset_writes", 32'(wr_cnt - w0), 32'd20);
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    check("midreset_sb_empty", 32'(sb_q.size()), 32'd0);

    // i_start during STREAM must be ignored.
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    start_xfer(10, 1);
    stream(64, 1'b0, 0, 30, cyc);
    drain();
    repeat (3) tick();
    check("spurious_start_writes", 32'(wr_cnt - w0), 32'd64);
    check("spurious_start_done", 32'(done_cnt - d0), 32'd1);
    check("spurious_start_last_addr", 32'(last_addr), 32'h2AFC);
    check("spurious_start_no_err", 32'(err_cnt - e0), 32'd0);
    check("spurious_start_idle", 32'(bus.o_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
